iq_symbol_demodulator: RTL

- Parametrised BPSK/QPSK correlating demodulator for the receiver chain.
- Accepts unsigned offset-binary samples with a valid strobe. Drives a phase index to the external sine/cosine wave tables and correlates each sample against the returned references over one symbol period.
- Emits one decided symbol per period on a valid/ready output, with confidence and overflow flags.
- Successor to the single-channel, fixed-length, BPSK-only demodulator: adds QPSK, multi-cycle symbols, an input handshake and output backpressure.

---
 rtl/iq_symbol_demodulator.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/iq_symbol_demodulator.sv
// BPSK/QPSK correlating demodulator: correlates offset-binary samples against external
// sine/cosine tables over one symbol period and emits decided symbols on valid/ready.
module iq_symbol_demodulator #(
  parameter int DATA_WIDTH        = 8,
  parameter int WAVELENGTH        = 16,
  parameter int CYCLES_PER_SYMBOL = 1,
  parameter int OFFSET            = 2 ** (DATA_WIDTH - 1),
  parameter int THRESHOLD         = 64,
  parameter int SKIP              = WAVELENGTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          qpsk_mode,
  input  logic [DATA_WIDTH-1:0]         sample_in,
  input  logic                          sample_valid,
  output logic [$clog2(WAVELENGTH)-1:0] phase_out,
  input  logic [DATA_WIDTH-1:0]         ref_sin,
  input  logic [DATA_WIDTH-1:0]         ref_cos,
  output logic [1:0]                    sym_data,
  output logic                          sym_conf,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  output logic                          overflow
);

  localparam int SYM_LEN = WAVELENGTH * CYCLES_PER_SYMBOL;
  localparam int PH_W    = $clog2(WAVELENGTH);
  localparam int CNT_W   = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int SKIP_W  = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam int SMP_W   = DATA_WIDTH + 1;
  localparam int PROD_W  = 2 * DATA_WIDTH + 2;
  localparam int ACC_W   = PROD_W + $clog2(SYM_LEN);

  localparam logic signed [SMP_W-1:0] ZERO_LVL  = SMP_W'(OFFSET);
  localparam logic signed [ACC_W-1:0] THR       = ACC_W'(THRESHOLD);
  localparam logic [PH_W-1:0]         PH_LAST   = PH_W'(WAVELENGTH - 1);
  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(SYM_LEN - 1);
  localparam logic [SKIP_W-1:0]       SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_RUN} state_t;

  state_t                    state, state_next;
  logic                      mode_qpsk;
  logic [SKIP_W-1:0]         skip_cnt;
  logic [CNT_W-1:0]          sym_cnt;
  logic signed [SMP_W-1:0]   samp_p0;
  logic                      vld_p0;
  logic signed [ACC_W-1:0]   acc_i, acc_q;
  logic signed [SMP_W-1:0]   rsin_s, rcos_s;
  logic signed [PROD_W-1:0]  prod_i, prod_q;
  logic signed [ACC_W-1:0]   sum_i, sum_q;
  logic                      run_now, sym_end;
  logic [1:0]                dec_data;
  logic                      dec_conf;

  function automatic logic signed [SMP_W-1:0] remove_offset(input logic [DATA_WIDTH-1:0] v);
    return $signed({1'b0, v}) - ZERO_LVL;
  endfunction

  function automatic logic exceeds_thr(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] mag;
    mag = v[ACC_W-1] ? -v : v;
    return mag > THR;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (enable) state_next = (SKIP == 0) ? ST_RUN : ST_SKIP;
      ST_SKIP: if (sample_valid && skip_cnt == SKIP_LAST) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
    if (!enable) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_qpsk <= 1'b0;
      skip_cnt  <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && enable) mode_qpsk <= qpsk_mode;
      if (state == ST_SKIP && enable) begin
        if (sample_valid) skip_cnt <= skip_cnt + SKIP_W'(1);
      end else begin
        skip_cnt <= '0;
      end
    end
  end

  assign run_now = (state == ST_RUN) && enable;

  // Stage p0: sample registered alongside the table lookup for its phase
  always_ff @(posedge clk) begin
    if (reset || !run_now) begin
      phase_out <= '0;
      sym_cnt   <= '0;
      vld_p0    <= 1'b0;
      samp_p0   <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
    end else begin
      vld_p0 <= sample_valid;
      if (sample_valid) begin
        samp_p0   <= remove_offset(sample_in);
        phase_out <= (phase_out == PH_LAST) ? '0 : phase_out + PH_W'(1);
      end
      if (vld_p0) begin
        if (sym_cnt == CNT_LAST) begin
          sym_cnt <= '0;
          acc_i   <= '0;
          acc_q   <= '0;
        end else begin
          sym_cnt <= sym_cnt + CNT_W'(1);
          acc_i   <= sum_i;
          acc_q   <= mode_qpsk ? sum_q : '0;
        end
      end
    end
  end

  // Stage p1: product with the reference that arrived one cycle after the sample
  assign rsin_s = remove_offset(ref_sin);
  assign rcos_s = remove_offset(ref_cos);
  assign prod_i = PROD_W'(samp_p0) * PROD_W'(rsin_s);
  assign prod_q = PROD_W'(samp_p0) * PROD_W'(rcos_s);
  assign sum_i  = acc_i + ACC_W'(prod_i);
  assign sum_q  = acc_q + ACC_W'(prod_q);

  assign sym_end  = run_now && vld_p0 && (sym_cnt == CNT_LAST);
  assign dec_data = {mode_qpsk & sum_q[ACC_W-1], sum_i[ACC_W-1]};
  assign dec_conf = exceeds_thr(sum_i) && (!mode_qpsk || exceeds_thr(sum_q));

  // Output register: a completed symbol is dropped only when the held one is not being taken
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_data  <= 2'b00;
      sym_conf  <= 1'b0;
      sym_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (sym_end) begin
        if (!sym_valid || sym_ready) begin
          sym_data  <= dec_data;
          sym_conf  <= dec_conf;
          sym_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
      end
      if (state != ST_IDLE && state_next == ST_IDLE) overflow <= 1'b0;
    end
  end

endmodule
